sort_checker_avalon: RTL and testbench
======================================

SORT_CHECKER_AVALON -- requirements
Module: sort_checker_avalon

Interface
REQ-001 Parameter DWIDTH, default 4, data beat width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 5, maximum legal beats per packet.
REQ-003 Parameter CNT_WIDTH, default 16, width of the packet and error counters.
REQ-004 clk_i  input  1  sole clock, all logic on rising edge.
REQ-005 arst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 snk_data_i  input  DWIDTH  Avalon-ST sink data.
REQ-007 snk_valid_i  input  1  sink valid.
REQ-008 snk_startofpacket_i  input  1  sink start of packet.
REQ-009 snk_endofpacket_i  input  1  sink end of packet.
REQ-010 snk_ready_o  output  1  sink ready, registered.
REQ-011 pkt_done_o  output  1  one-cycle pulse, packet verdict valid.
REQ-012 pkt_len_o  output  $clog2(MAX_PKT_LEN+1)+1  beat count of the reported packet, saturating at MAX_PKT_LEN+1.
REQ-013 pkt_ok_o  output  1  reported packet had no error.
REQ-014 err_order_o / err_framing_o / err_len_o  output  1 each  error cause of the reported packet.
REQ-015 pkt_cnt_o / err_cnt_o  output  CNT_WIDTH each  saturating totals of reported packets and failed packets.

Function
REQ-016 A beat transfers only on a rising edge with snk_valid_i && snk_ready_o; the block ignores all sink inputs otherwise.
REQ-017 The FSM has states IDLE and IN_PKT; reset enters IDLE.
REQ-018 IDLE + transfer with sop: capture data as prev, len=1, clear error flags, go to IN_PKT; with eop also set, report immediately and stay in IDLE.
REQ-019 IDLE + transfer without sop: discard beat, report a packet with len=0 and err_framing=1.
REQ-020 IN_PKT + transfer without sop: len increments (saturating at MAX_PKT_LEN+1); data < prev sets sticky err_order; prev updates to data; equal values are legal.
REQ-021 IN_PKT + transfer with sop: report the open packet with err_framing=1, then start a new packet from this beat exactly as in REQ-018.
REQ-022 len exceeding MAX_PKT_LEN sets sticky err_len; the block keeps consuming until eop.
REQ-023 A transfer with eop in IN_PKT closes the packet and returns to IDLE.
REQ-024 Each verdict is registered: pkt_done_o pulses for one cycle in the cycle after the closing transfer.
REQ-025 pkt_len_o, pkt_ok_o and the err_*_o outputs hold their values until the next verdict.
REQ-026 pkt_ok_o = !(err_order || err_framing || err_len).
REQ-027 pkt_cnt_o increments on every pkt_done_o; err_cnt_o increments when pkt_ok_o=0; both saturate at all-ones.
REQ-028 With the feature macro undefined, snk_ready_o is 0 in the cycle after reset release, then constantly 1.

Reset
REQ-029 While arst_n_i=0: FSM in IDLE, snk_ready_o=0, pkt_done_o=0, pkt_ok_o=0, pkt_len_o=0, all err_*_o=0, both counters=0, prev=0.
REQ-030 Reset asserted mid-packet drops the packet silently, with no verdict.

Configuration
REQ-031 Macro SORT_CHECKER_BACKPRESSURE_EN: when defined, snk_ready_o follows bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5, advancing every cycle) after reset release; when undefined, REQ-028 applies and no LFSR is built.

Structure
REQ-032 Package sort_checker_pkg holds the state_t enum (IDLE, IN_PKT) and the LFSR seed/tap constants.
REQ-033 The LFSR is sub-module sort_checker_lfsr, instantiated only under SORT_CHECKER_BACKPRESSURE_EN.

Verification
REQ-034 Packet 1,2,2,4 (sop on beat 1, eop on beat 4) -> one pulse, pkt_len_o=4, pkt_ok_o=1, pkt_cnt_o=1, err_cnt_o=0.
REQ-035 Packet 3,1,5 -> pkt_ok_o=0, err_order_o=1, pkt_len_o=3, err_cnt_o=1.
REQ-036 Six beats 0..5 with MAX_PKT_LEN=5 -> err_len_o=1, pkt_len_o=6.
REQ-037 sop on 2,3, then a new sop on 7 with eop -> two pulses: first len=2 err_framing_o=1; second len=1 pkt_ok_o=1.
REQ-038 Single beat with sop+eop while IDLE -> pulse, len=1, ok=1; a lone beat without sop -> len=0, err_framing_o=1.
REQ-039 Reset asserted after two beats of an open packet -> no pulse, counters=0; the next clean packet reports ok with pkt_cnt_o=1.

Source files
------------

// File: rtl/sort_checker_pkg.sv
// Shared types and constants for the Avalon-ST sort checker.
package sort_checker_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    // Fibonacci LFSR, taps 8,6,5,4 expressed as a mask on bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/sort_checker_lfsr.sv
// 8-bit Fibonacci LFSR used to pace snk_ready_o.
// Only built when SORT_CHECKER_BACKPRESSURE_EN is defined.
module sort_checker_lfsr
    import sort_checker_pkg::*;
(
    input  logic clk_i,
    input  logic arst_n_i,
    output logic bit_o
);

    logic [7:0] lfsr_q, lfsr_d;

    // Shift left, feeding back the XOR of the tapped bits
    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // LFSR state register, reloads the seed on reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/sort_checker_avalon.sv
// Avalon-ST sink that checks each packet is non-decreasing, correctly framed and
// no longer than MAX_PKT_LEN beats, and reports one registered verdict per packet.
// Optional macro SORT_CHECKER_BACKPRESSURE_EN paces snk_ready_o from an LFSR.
module sort_checker_avalon
    import sort_checker_pkg::*;
#(
    parameter int unsigned DWIDTH      = 4,
    parameter int unsigned MAX_PKT_LEN = 5,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic [DWIDTH-1:0]                snk_data_i,
    input  logic                             snk_valid_i,
    input  logic                             snk_startofpacket_i,
    input  logic                             snk_endofpacket_i,
    output logic                             snk_ready_o,
    output logic                             pkt_done_o,
    output logic [$clog2(MAX_PKT_LEN+1):0]   pkt_len_o,
    output logic                             pkt_ok_o,
    output logic                             err_order_o,
    output logic                             err_framing_o,
    output logic                             err_len_o,
    output logic [CNT_WIDTH-1:0]             pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]             err_cnt_o
);

    localparam int unsigned LenW = $clog2(MAX_PKT_LEN + 1) + 1;
    localparam logic [LenW-1:0] LenMax = LenW'(MAX_PKT_LEN);
    localparam logic [LenW-1:0] LenSat = LenW'(MAX_PKT_LEN + 1);

    state_t                state_q, state_d;
    logic [DWIDTH-1:0]     prev_q, prev_d;
    logic [LenW-1:0]       len_q, len_d, len_inc;
    logic                  ord_q, ord_d, lerr_q, lerr_d;
    // A sop+eop beat inside an open packet yields two verdicts; the second waits here
    logic                  pend_q, pend_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d, vok_q, vok_d;
    logic [LenW-1:0]       vlen_q, vlen_d;
    logic                  vord_q, vord_d, vfrm_q, vfrm_d, vlerr_q, vlerr_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
    logic                  report;
    logic [LenW-1:0]       rep_len;
    logic                  rep_ord, rep_frm, rep_lerr, rep_ok;
    logic                  xfer, pace;

    assign xfer = snk_valid_i && ready_q;

`ifdef SORT_CHECKER_BACKPRESSURE_EN
    sort_checker_lfsr u_lfsr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .bit_o    (pace)
    );
`else
    assign pace = 1'b1;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (snk_startofpacket_i && !snk_endofpacket_i) state_d = IN_PKT;
                end
                IN_PKT: begin
                    if (snk_endofpacket_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Packet tracking and verdict next-state
    always_comb begin
        prev_d    = prev_q;
        len_d     = len_q;
        ord_d     = ord_q;
        lerr_d    = lerr_q;
        pend_d    = 1'b0;
        report    = 1'b0;
        rep_len   = '0;
        rep_ord   = 1'b0;
        rep_frm   = 1'b0;
        rep_lerr  = 1'b0;
        len_inc   = (len_q == LenSat) ? len_q : len_q + LenW'(1);
        if (pend_q) begin
            // Deferred single-beat packet; ready was low so no transfer this cycle
            report  = 1'b1;
            rep_len = LenW'(1);
        end else if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (snk_startofpacket_i) begin
                        prev_d = snk_data_i;
                        len_d  = LenW'(1);
                        ord_d  = 1'b0;
                        lerr_d = 1'b0;
                        if (snk_endofpacket_i) begin
                            report  = 1'b1;
                            rep_len = LenW'(1);
                        end
                    end else begin
                        report  = 1'b1;
                        rep_frm = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (snk_startofpacket_i) begin
                        report   = 1'b1;
                        rep_len  = len_q;
                        rep_ord  = ord_q;
                        rep_frm  = 1'b1;
                        rep_lerr = lerr_q;
                        prev_d   = snk_data_i;
                        len_d    = LenW'(1);
                        ord_d    = 1'b0;
                        lerr_d   = 1'b0;
                        pend_d   = snk_endofpacket_i;
                    end else begin
                        len_d  = len_inc;
                        ord_d  = ord_q | (snk_data_i < prev_q);
                        lerr_d = lerr_q | (len_inc > LenMax);
                        prev_d = snk_data_i;
                        if (snk_endofpacket_i) begin
                            report   = 1'b1;
                            rep_len  = len_d;
                            rep_ord  = ord_d;
                            rep_lerr = lerr_d;
                        end
                    end
                end
                default: ;
            endcase
        end

        rep_ok    = !(rep_ord || rep_frm || rep_lerr);
        done_d    = report;
        vlen_d    = vlen_q;
        vok_d     = vok_q;
        vord_d    = vord_q;
        vfrm_d    = vfrm_q;
        vlerr_d   = vlerr_q;
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (report) begin
            vlen_d  = rep_len;
            vok_d   = rep_ok;
            vord_d  = rep_ord;
            vfrm_d  = rep_frm;
            vlerr_d = rep_lerr;
            if (!(&pkt_cnt_q)) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            if (!rep_ok && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
        // Stall one cycle while a deferred verdict drains
        ready_d = pace && !pend_d;
    end

    // Datapath and verdict registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            prev_q    <= '0;
            len_q     <= '0;
            ord_q     <= 1'b0;
            lerr_q    <= 1'b0;
            pend_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            vlen_q    <= '0;
            vok_q     <= 1'b0;
            vord_q    <= 1'b0;
            vfrm_q    <= 1'b0;
            vlerr_q   <= 1'b0;
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            len_q     <= len_d;
            ord_q     <= ord_d;
            lerr_q    <= lerr_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            vlen_q    <= vlen_d;
            vok_q     <= vok_d;
            vord_q    <= vord_d;
            vfrm_q    <= vfrm_d;
            vlerr_q   <= vlerr_d;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign snk_ready_o   = ready_q;
    assign pkt_done_o    = done_q;
    assign pkt_len_o     = vlen_q;
    assign pkt_ok_o      = vok_q;
    assign err_order_o   = vord_q;
    assign err_framing_o = vfrm_q;
    assign err_len_o     = vlerr_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_sort_checker_avalon.sv
// Directed bench for sort_checker_avalon with hand-computed verdicts.
`define CHK(TAG, OBS, EXP) \
    begin \
        vectors++; \
        assert ((OBS) === (EXP)) else begin \
            miscompares++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

module tb_sort_checker_avalon;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  data;
    logic        valid, sop, eop;
    logic        ready, done, ok, e_ord, e_frm, e_len;
    logic [3:0]  len;
    logic [15:0] pkt_cnt, err_cnt;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    sort_checker_avalon #(
        .DWIDTH      (4),
        .MAX_PKT_LEN (5),
        .CNT_WIDTH   (16)
    ) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .snk_data_i          (data),
        .snk_valid_i         (valid),
        .snk_startofpacket_i (sop),
        .snk_endofpacket_i   (eop),
        .snk_ready_o         (ready),
        .pkt_done_o          (done),
        .pkt_len_o           (len),
        .pkt_ok_o            (ok),
        .err_order_o         (e_ord),
        .err_framing_o       (e_frm),
        .err_len_o           (e_len),
        .pkt_cnt_o           (pkt_cnt),
        .err_cnt_o           (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) pulses++;

    // One beat: wait (bounded) for ready, present it across one rising edge,
    // return 1 time unit after that edge.
    task automatic beat(input logic [3:0] d, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $error("FAIL ready_timeout: observed %0h expected %0h", ready, 1'b1);
        end
        data  = d;
        sop   = s;
        eop   = e;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic [3:0] l, input logic o,
                           input logic eo, input logic ef, input logic el,
                           input logic [15:0] pc, input logic [15:0] ec);
        `CHK({tag, "_done"}, done, 1'b1)
        `CHK({tag, "_len"}, len, l)
        `CHK({tag, "_ok"}, ok, o)
        `CHK({tag, "_order"}, e_ord, eo)
        `CHK({tag, "_framing"}, e_frm, ef)
        `CHK({tag, "_lenerr"}, e_len, el)
        `CHK({tag, "_pktcnt"}, pkt_cnt, pc)
        `CHK({tag, "_errcnt"}, err_cnt, ec)
    endtask

    initial begin
        int p;
        arst_n = 1'b0;
        data   = '0;
        valid  = 1'b0;
        sop    = 1'b0;
        eop    = 1'b0;
        repeat (2) @(negedge clk);
        `CHK("rst_ready", ready, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_ok", ok, 1'b0)
        `CHK("rst_len", len, 4'd0)
        `CHK("rst_errs", {e_ord, e_frm, e_len}, 3'b000)
        `CHK("rst_cnts", {pkt_cnt, err_cnt}, 32'd0)

        arst_n = 1'b1;
        #1;
        `CHK("rel_ready0", ready, 1'b0)
        @(posedge clk);
        #1;
`ifndef SORT_CHECKER_BACKPRESSURE_EN
        `CHK("rel_ready1", ready, 1'b1)
`endif

        // Non-decreasing packet with an equal pair
        p = pulses;
        beat(4'd1, 1, 0); beat(4'd2, 0, 0); beat(4'd2, 0, 0); beat(4'd4, 0, 1);
        verdict("p1", 4'd4, 1, 0, 0, 0, 16'd1, 16'd0);
        @(posedge clk);
        #1;
        `CHK("p1_pulse_end", done, 1'b0)
        `CHK("p1_len_hold", len, 4'd4)
        `CHK("p1_one_pulse", pulses - p, 1)

        // Order violation
        beat(4'd3, 1, 0); beat(4'd1, 0, 0); beat(4'd5, 0, 1);
        verdict("p2", 4'd3, 0, 1, 0, 0, 16'd2, 16'd1);

        // Six beats, one over the limit
        beat(4'd0, 1, 0);
        for (int i = 1; i < 5; i++) beat(4'(i), 0, 0);
        beat(4'd5, 0, 1);
        verdict("p3", 4'd6, 0, 0, 0, 1, 16'd3, 16'd2);

        // Open packet interrupted by sop+eop: two verdicts back to back
        p = pulses;
        beat(4'd2, 1, 0); beat(4'd3, 0, 0); beat(4'd7, 1, 1);
        verdict("p4a", 4'd2, 0, 0, 1, 0, 16'd4, 16'd3);
        @(posedge clk);
        #1;
        verdict("p4b", 4'd1, 1, 0, 0, 0, 16'd5, 16'd3);
        @(negedge clk);
        `CHK("p4_two_pulses", pulses - p, 2)

        // Single-beat packet, then a lone beat without sop
        beat(4'd9, 1, 1);
        verdict("p5", 4'd1, 1, 0, 0, 0, 16'd6, 16'd3);
        beat(4'd4, 0, 0);
        verdict("p6", 4'd0, 0, 0, 1, 0, 16'd7, 16'd4);
        repeat (3) @(negedge clk);
        `CHK("p6_hold_len", len, 4'd0)
        `CHK("p6_hold_frm", e_frm, 1'b1)

        // Eight beats: length saturates at MAX_PKT_LEN+1
        beat(4'd0, 1, 0);
        for (int i = 0; i < 6; i++) beat(4'd0, 0, 0);
        beat(4'd0, 0, 1);
        verdict("p7", 4'd6, 0, 0, 0, 1, 16'd8, 16'd5);

        // Reset mid-packet drops it silently
        beat(4'd1, 1, 0); beat(4'd2, 0, 0);
        p = pulses;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        `CHK("mid_rst_cnts", {pkt_cnt, err_cnt}, 32'd0)
        `CHK("mid_rst_done", done, 1'b0)
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        `CHK("mid_rst_no_pulse", pulses - p, 0)
        beat(4'd5, 1, 0); beat(4'd6, 0, 1);
        verdict("p8", 4'd2, 1, 0, 0, 0, 16'd1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
